mul_rep_add_seq: RTL and testbench

- Parametrised sequential multiplier that computes the product by repeated addition, controlled by an internal FSM.
- Successor to the fixed 16-bit unsigned multiply-by-add datapath/controller pair. Adds generic WIDTH, a per-operation signed mode, a minimum-iteration operand swap, parallel operand load, and a busy/done handshake.
- Used as a small-area multiplier wherever latency is not critical.

---
 rtl/mul_rep_add_seq.sv | 164 ++++++++++++++++
 tb/tb_mul_rep_add_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rep_add_seq.sv
// ---------------------------------------------------------------------------
// mul_rep_add_seq
//
// Sequential WIDTH x WIDTH multiplier that builds the product by repeated
// addition. Operands are captured when the block is idle, reduced to
// magnitudes, and the smaller magnitude is used as the iteration count so
// that the number of additions is min(|A|,|B|). The sign is applied in a
// final step, so one unsigned add loop serves both signed and unsigned modes.
//
// Parameters
//   WIDTH      operand width in bits (2..32)
//   SIGNED_EN  1: signed_mode input is honoured, 0: always unsigned
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        request, only looked at while idle
//   signed_mode  operands are two's complement (captured with start)
//   a_in, b_in   operands (captured with start)
//   busy         high while an operation is in progress
//   done         one-cycle pulse, product valid from this cycle onward
//   product      registered 2*WIDTH-bit result, held until the next done
// ---------------------------------------------------------------------------
module mul_rep_add_seq #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_SIGN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 sgn_q, sgn_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  // Magnitudes of the captured operands. The most negative value maps onto
  // itself, which read as unsigned is exactly 2^(WIDTH-1), so no extra bit
  // is needed.
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             a_neg;
  logic             b_neg;

  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];
  assign mag_a = a_neg ? (~a_q + ONE_W) : a_q;
  assign mag_b = b_neg ? (~b_q + ONE_W) : b_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      m_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      p_q       <= p_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    p_d       = p_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          sgn_d   = signed_mode & SIGNED_EN;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // A zero operand forces a positive result so -0 never appears.
        neg_d = (a_neg ^ b_neg) & (mag_a != '0) & (mag_b != '0);
        // Counting down the smaller magnitude minimises iterations;
        // a tie counts on B.
        if (mag_a < mag_b) begin
          cnt_d = mag_a;
          m_d   = mag_b;
        end else begin
          cnt_d = mag_b;
          m_d   = mag_a;
        end
        p_d     = '0;
        state_d = S_CALC;
      end

      S_CALC: begin
        if (cnt_q != '0) begin
          p_d   = p_q + {{WIDTH{1'b0}}, m_q};
          cnt_d = cnt_q - ONE_W;
        end else begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        product_d = neg_q ? (~p_q + ONE_P) : p_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_rep_add_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_rep_add_seq
//
// Self-checking bench for mul_rep_add_seq. A 16-bit signed-capable instance
// runs directed and random operations against a transaction-level model
// (product from plain integer multiplication, latency from min(|A|,|B|)+3),
// compared every cycle. Two 8-bit instances (SIGNED_EN=1 and SIGNED_EN=0)
// share stimulus and are checked against hand-computed results.
// ---------------------------------------------------------------------------
module tb_mul_rep_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] prod16;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8s, done8s, busy8u, done8u;
  logic [15:0] prod8s, prod8u;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  bit chk_en = 1'b0;

  mul_rep_add_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) u16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .a_in(a16), .b_in(b16), .busy(busy16), .done(done16), .product(prod16)
  );

  mul_rep_add_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u8s (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a_in(a8), .b_in(b8), .busy(busy8s), .done(done8s), .product(prod8s)
  );

  mul_rep_add_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) u8u (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a_in(a8), .b_in(b8), .busy(busy8u), .done(done8u), .product(prod8u)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (16-bit instance) ----------------
  function automatic longint sval(input logic [15:0] v, input logic sm);
    return sm ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint mag(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint p;
    p = sval(a, sm) * sval(b, sm);
    return 32'(p);
  endfunction

  function automatic int lat16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint ma, mb;
    ma = mag(sval(a, sm));
    mb = mag(sval(b, sm));
    return int'(((ma < mb) ? ma : mb) + 3);
  endfunction

  // Transaction model: an accepted request completes lat16 edges later.
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  logic [31:0] m_prod   = '0;
  logic [31:0] m_pend   = '0;
  int          m_left   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_prod   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_left == 0) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_prod   <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start16) begin
        m_active <= 1'b1;
        m_left   <= lat16(a16, b16, sm16) - 1;
        m_pend   <= ref16(a16, b16, sm16);
      end
    end
  end

  // Per-cycle comparison of the 16-bit instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy16", 64'(busy16), 64'(m_active));
      chk("done16", 64'(done16), 64'(m_done));
      chk("prod16", 64'(prod16), 64'(m_prod));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    @(negedge clk);
    a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start16 = 1'b0;
    // Inputs need not stay stable after acceptance.
    a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
  endtask

  task automatic wait16(input string nm, input int exp_edges, input logic [31:0] exp_p);
    bit seen = 1'b0;
    int lat;
    while (!seen && (cyc - acc_cyc) < exp_edges + 20) begin
      @(posedge clk);
      #1;
      if (done16) seen = 1'b1;
    end
    lat = seen ? (cyc - acc_cyc) : -1;
    $display("txn %s: edges=%0d product=%h", nm, lat, prod16);
    chk({nm, "_lat"}, 64'(lat), 64'(exp_edges));
    if (seen) begin
      chk({nm, "_prod"}, 64'(prod16), 64'(exp_p));
      chk({nm, "_busy_in_done"}, 64'(busy16), 64'(0));
    end
  endtask

  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input int es, input logic [15:0] ps, input int eu, input logic [15:0] pu);
    int t0;
    int ls = -1;
    int lu = -1;
    logic [15:0] gs = '0;
    logic [15:0] gu = '0;
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    while ((ls < 0 || lu < 0) && (cyc - t0) < 400) begin
      @(posedge clk);
      #1;
      if (done8s && ls < 0) begin ls = cyc - t0; gs = prod8s; end
      if (done8u && lu < 0) begin lu = cyc - t0; gu = prod8u; end
    end
    $display("txn %s: s_edges=%0d s_prod=%h u_edges=%0d u_prod=%h", nm, ls, gs, lu, gu);
    chk({nm, "_s_lat"},  64'(ls), 64'(es));
    chk({nm, "_s_prod"}, 64'(gs), 64'(ps));
    chk({nm, "_u_lat"},  64'(lu), 64'(eu));
    chk({nm, "_u_prod"}, 64'(gu), 64'(pu));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy16", 64'(busy16), 64'(0));
    chk("rst_done16", 64'(done16), 64'(0));
    chk("rst_prod16", 64'(prod16), 64'(0));
    chk("rst_busy8s", 64'(busy8s), 64'(0));
    chk("rst_prod8u", 64'(prod8u), 64'(0));
    chk_en = 1'b1;

    // Directed 16-bit cases with hand-computed expectations
    pulse16(16'd17, 16'd5, 1'b0);      wait16("u17x5",   8, 32'd85);
    pulse16(16'd0, 16'd40000, 1'b0);   wait16("u0x40000", 3, 32'd0);
    pulse16(16'd0, 16'hFFFB, 1'b1);    wait16("s0xm5",   3, 32'd0);
    pulse16(16'hFFFD, 16'd7, 1'b1);    wait16("sm3x7",   6, 32'hFFFF_FFEB);
    pulse16(16'hFFFD, 16'hFFF9, 1'b1); wait16("sm3xm7",  6, 32'h0000_0015);
    pulse16(16'h8000, 16'd3, 1'b1);    wait16("sminx3",  6, 32'hFFFE_8000);

    // Start during CALC is ignored
    pulse16(16'd17, 16'd5, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a16 = 16'd9; b16 = 16'd9; sm16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait16("ignore9x9", 8, 32'd85);
    // Request raised in the done cycle is accepted at the next edge
    pulse16(16'd2, 16'd3, 1'b0);       wait16("b2b2x3",  5, 32'd6);

    // Reset mid-CALC aborts without a done
    pulse16(16'd17, 16'd5, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy16), 64'(0));
    chk("abort_prod", 64'(prod16), 64'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done16), 64'(0));
    end

    // 8-bit instances: SIGNED_EN=1 (s) and SIGNED_EN=0 (u) side by side
    run8("m80x80", 8'h80, 8'h80, 1'b1, 131, 16'h4000, 131, 16'h4000);
    run8("uFFxFF", 8'hFF, 8'hFF, 1'b0, 258, 16'hFE01, 258, 16'hFE01);
    run8("sFFx2",  8'hFF, 8'h02, 1'b1,   4, 16'hFFFE,   5, 16'h01FE);
    run8("s80x7F", 8'h80, 8'h7F, 1'b1, 130, 16'hC080, 130, 16'h3F80);

    // Randomized 16-bit operations; one operand kept small to bound latency
    for (int i = 0; i < 60; i++) begin
      logic        sm;
      logic [15:0] a, b, sml, big;
      int          kind, s;
      sm   = 1'($urandom);
      kind = int'($urandom_range(0, 3));
      s    = int'($urandom_range(0, 60));
      sml  = (sm && $urandom_range(0, 1) == 1) ? 16'(-s) : 16'(s);
      big  = 16'($urandom);
      case (kind)
        0: begin a = sml; b = big; end
        1: begin a = big; b = sml; end
        2: begin a = sml; b = 16'($urandom_range(0, 50)); end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
          b = sml;
        end
      endcase
      pulse16(a, b, sm);
      wait16($sformatf("rnd%0d", i), lat16(a, b, sm), ref16(a, b, sm));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
